decoder_rr_arbiter: RTL and testbench
=====================================

// Module: decoder_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the 5-to-32 address decoder among NUM_REQ requesters.
//   Picks one pending requester and drives its index on the decoder address bus, so the
//   selected decoder output (wordline) belongs to that requester.
//   Limits each tenure to MAX_HOLD cycles. Sits directly upstream of the decoder A input.
// PARAMETERS
//   NUM_REQ   32  number of requesters; must satisfy 2 <= NUM_REQ <= 2**ADDR_W
//   ADDR_W    5   decoder address width (width of A)
//   MAX_HOLD  4   max consecutive grant cycles per tenure; 0 = unlimited
// PORTS
//   clk      in   1        single clock, all state on rising edge
//   reset    in   1        synchronous, active-high reset
//   req      in   NUM_REQ  level request per requester; held high while access is wanted
//   grant    out  NUM_REQ  registered one-hot grant; all-zero when idle
//   A        out  ADDR_W   registered index of the current owner; drives the decoder A input
//   A_valid  out  1        high while grant is nonzero
//   busy     out  1        equals A_valid
// BEHAVIOUR
//   Reset (edge with reset=1): state=IDLE, grant=0, A=0, A_valid=0, ptr=0, hold_cnt=0.
//     Reset overrides any tenure in progress; outputs are all zero after that edge.
//   Pick function: first index i with req[i]=1, searching ptr, ptr+1, ... and wrapping at
//     NUM_REQ (not at 2**ADDR_W).
//   IDLE: if |req at an edge, then at that edge: state=GRANT, owner=pick, grant=1<<owner,
//     A=owner, A_valid=1, hold_cnt=1. Grant latency is 1 cycle from req sampled.
//   GRANT (owner g): release at an edge when req[g]==0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
//     On release: ptr=(g+1) mod NUM_REQ, and re-arbitrate in the same edge using the new ptr.
//       If pick exists, it becomes the new owner with hold_cnt=1 (back-to-back, no idle gap).
//       Otherwise: state=IDLE, grant=0, A=0, A_valid=0.
//     Forced release (hold limit) with only g requesting: g is re-granted in the same edge;
//       A_valid stays high.
//     No release: hold_cnt increments. hold_cnt saturates (width $clog2(MAX_HOLD+1),
//       minimum 1 bit). With MAX_HOLD=0, hold_cnt is ignored.
//   Owner drops req in cycle t: grant/A change at the edge ending cycle t.
//     Arbiter is never combinational from req to grant.
//   ptr updates only on release; an initial IDLE grant does not move ptr.
//   Requests that arrive or vanish in the same cycle as a release: only the sampled req
//     vector at that edge matters.
//   Invariants: grant is one-hot or zero; grant==(A_valid ? 1<<A : 0); A < NUM_REQ.
//   Downstream decoder registers A. The decoded one-hot appears 1 cycle after A; the
//     arbiter does not compensate.
// STRUCTURE
//   Shared package decoder_pkg holds:
//     - ADDR_W default (5)
//     - state typedef: enum {IDLE, GRANT}
//     - function onehot(idx)
//   Sub-module rr_priority_pick (combinational).
//     Inputs: req, ptr. Outputs: found, idx.
//     Implementation: doubled-vector priority encoder.
//   Top holds the FSM, ptr, hold_cnt and output registers. The decoder is instantiated
//     alongside at the integration level, not inside this block.
// TESTING
//   1. reset; req=32'h0000_0001, then drop req after 3 grant cycles
//      -> grant=1, A=0, A_valid=1 from 1 cycle after req;
//      -> grant=0, A_valid=0 the edge after req drops.
//   2. MAX_HOLD=4, req=32'hFFFF_FFFF held
//      -> A steps 0,1,...,31,0, each value for exactly 4 cycles, no A_valid gap;
//      -> decoder Z==1<<A one cycle later.
//   3. req=(1<<3)|(1<<30), each requester drops req after 2 granted cycles then re-raises
//      -> owner order 3,30,3,30 (wrap via NUM_REQ).
//   4. MAX_HOLD=2, only req[7] held 10 cycles
//      -> A=7 and A_valid=1 continuously; no idle cycle at forced releases.
//   5. reset pulsed while owner=12; then req=(1<<0)|(1<<5)
//      -> after reset edge all outputs 0; then requester 0 wins first, then 5.
//   6. MAX_HOLD=0, req[9] held 100 cycles with req[10] pending
//      -> grant stays 1<<9 for all 100 cycles;
//      -> A=10 the edge after req[9] drops.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder address arbiter: default address width,
// arbiter state encoding and a one-hot helper.
package decoder_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int ONEHOT_MAX     = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Callers truncate the result to their own requester count (at most ONEHOT_MAX).
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        logic [ONEHOT_MAX-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at
// NUM_REQ, using a doubled request vector rotated down by ptr.
module rr_priority_pick
    import decoder_pkg::*;
#(
    parameter int NUM_REQ = 32,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0]  ptr,
    output logic               found,
    output logic [ADDR_W-1:0]  idx
);
    localparam logic [ADDR_W:0] NUM_REQ_W = (ADDR_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   window;
    logic [ADDR_W-1:0]    offset;
    logic [ADDR_W:0]      sum;

    assign doubled = {req, req};
    assign window  = NUM_REQ'(doubled >> ptr);

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (window[i]) begin
                offset = ADDR_W'(i);
            end
        end
    end

    assign found = |req;
    assign sum   = {1'b0, ptr} + {1'b0, offset};
    assign idx   = (sum >= NUM_REQ_W) ? ADDR_W'(sum - NUM_REQ_W) : sum[ADDR_W-1:0];

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that shares the address decoder among NUM_REQ requesters,
// driving the owner's index on A with a per-tenure hold limit (0 = unlimited).
module decoder_rr_arbiter
    import decoder_pkg::*;
#(
    parameter int NUM_REQ  = 32,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ADDR_W-1:0]  A,
    output logic               A_valid,
    output logic               busy
);
    localparam int              HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [ADDR_W:0]   NUM_REQ_W  = (ADDR_W+1)'(NUM_REQ);

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [ADDR_W-1:0]   a_reg, a_next;
    logic                valid_reg, valid_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;

    logic                owner_req, hold_done, release_now, pick_found;
    logic [ADDR_W:0]     owner_inc;
    logic [ADDR_W-1:0]   ptr_after, pick_ptr, pick_idx;

    assign owner_req   = req[a_reg];
    assign hold_done   = (MAX_HOLD != 0) && (hold_reg == HOLD_LIMIT);
    assign release_now = (state_reg == GRANT) && (!owner_req || hold_done);
    assign owner_inc   = {1'b0, a_reg} + (ADDR_W+1)'(1);
    assign ptr_after   = (owner_inc == NUM_REQ_W) ? '0 : owner_inc[ADDR_W-1:0];

    // On release the pick already searches from the owner's successor, so a
    // new tenure starts on the same edge with no idle gap.
    assign pick_ptr = release_now ? ptr_after : ptr_reg;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        a_next     = a_reg;
        valid_next = valid_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        if (state_reg == IDLE || release_now) begin
            if (release_now) begin
                ptr_next = ptr_after;
            end
            if (pick_found) begin
                state_next = GRANT;
                grant_next = NUM_REQ'(onehot(32'(pick_idx)));
                a_next     = pick_idx;
                valid_next = 1'b1;
                hold_next  = HOLD_W'(1);
            end else begin
                state_next = IDLE;
                grant_next = '0;
                a_next     = '0;
                valid_next = 1'b0;
                hold_next  = '0;
            end
        end else if (hold_reg != '1) begin
            hold_next = hold_reg + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            a_reg     <= '0;
            valid_reg <= 1'b0;
            ptr_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            a_reg     <= a_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
        end
    end

    assign grant   = grant_reg;
    assign A       = a_reg;
    assign A_valid = valid_reg;
    assign busy    = valid_reg;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: three instances (hold limits 4, 2, unlimited)
// share one request stream and are compared each cycle against a queue-free reference model.
module tb_decoder_rr_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;

    logic [N-1:0] grant_o [3];
    logic [4:0]   a_o     [3];
    logic         valid_o [3];
    logic         busy_o  [3];

    int checks   = 0;
    int failures = 0;

    int holds    [3] = '{4, 2, 0};
    int m_active [3];
    int m_owner  [3];
    int m_ptr    [3];
    int m_cnt    [3];

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.NUM_REQ(N), .ADDR_W(5), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_o[0]),
        .A(a_o[0]), .A_valid(valid_o[0]), .busy(busy_o[0]));
    decoder_rr_arbiter #(.NUM_REQ(N), .ADDR_W(5), .MAX_HOLD(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_o[1]),
        .A(a_o[1]), .A_valid(valid_o[1]), .busy(busy_o[1]));
    decoder_rr_arbiter #(.NUM_REQ(N), .ADDR_W(5), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_o[2]),
        .A(a_o[2]), .A_valid(valid_o[2]), .busy(busy_o[2]));

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int p;
            if (reset) begin
                m_active[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
            end else if (m_active[m] == 0) begin
                p = pick(req, m_ptr[m]);
                if (p >= 0) begin
                    m_active[m] = 1; m_owner[m] = p; m_cnt[m] = 1;
                end
            end else if (!req[m_owner[m]] || (holds[m] != 0 && m_cnt[m] == holds[m])) begin
                m_ptr[m] = (m_owner[m] + 1) % N;
                p = pick(req, m_ptr[m]);
                if (p >= 0) begin
                    m_owner[m] = p; m_cnt[m] = 1;
                end else begin
                    m_active[m] = 0; m_owner[m] = 0;
                end
            end else begin
                m_cnt[m] = m_cnt[m] + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            logic [31:0] eg;
            eg = (m_active[m] != 0) ? (32'd1 << m_owner[m]) : 32'd0;
            check($sformatf("grant[h%0d]", holds[m]), grant_o[m], eg);
            check($sformatf("A[h%0d]", holds[m]), 32'(a_o[m]), 32'(m_owner[m]));
            check($sformatf("A_valid[h%0d]", holds[m]), 32'(valid_o[m]), 32'(m_active[m]));
            check($sformatf("busy[h%0d]", holds[m]), 32'(busy_o[m]), 32'(m_active[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int prev_a, run, n_seen, last_a;
        int order [4];
        int exp_order [4] = '{3, 30, 3, 30};

        reset = 1'b1;
        req   = '0;
        tick();
        check("reset_grant", grant_o[0], 32'd0);
        check("reset_valid", 32'(valid_o[0]), 32'd0);
        reset = 1'b0;

        // 1: single requester, dropped after 3 grant cycles
        req = 32'h0000_0001;
        tick();
        check("t1_grant", grant_o[0], 32'd1);
        tick();
        tick();
        req = '0;
        tick();
        check("t1_release", 32'(valid_o[0]), 32'd0);

        // 2: all requesting, hold limit rotates A every 4 cycles
        do_reset();
        req    = '1;
        prev_a = -1;
        run    = 0;
        for (int i = 0; i < 132; i++) begin
            tick();
            check("t2_valid", 32'(valid_o[0]), 32'd1);
            if (i == 128) check("t2_wrap", 32'(a_o[0]), 32'd0);
            if (32'(a_o[0]) != prev_a) begin
                if (prev_a != -1) check("t2_runlen", run, 32'd4);
                prev_a = 32'(a_o[0]);
                run    = 1;
            end else begin
                run++;
            end
        end

        // 3: two requesters, each drops after 2 granted cycles
        do_reset();
        n_seen = 0;
        last_a = -1;
        for (int i = 0; i < 16; i++) begin
            req = (32'd1 << 3) | (32'd1 << 30);
            if (m_active[0] != 0 && m_cnt[0] == 2) req[m_owner[0]] = 1'b0;
            tick();
            if (valid_o[0] && 32'(a_o[0]) != last_a) begin
                last_a = 32'(a_o[0]);
                if (n_seen < 4) order[n_seen] = last_a;
                n_seen++;
            end
        end
        check("t3_tenures", (n_seen >= 4) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), order[k], exp_order[k]);

        // 4: lone requester under hold limit 2 is re-granted without a gap
        do_reset();
        req = 32'd1 << 7;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_A", 32'(a_o[1]), 32'd7);
            check("t4_valid", 32'(valid_o[1]), 32'd1);
        end

        // 5: reset in the middle of a tenure
        req = 32'd1 << 12;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_grant", grant_o[0], 32'd0);
        check("t5_rst_A", 32'(a_o[0]), 32'd0);
        check("t5_rst_valid", 32'(valid_o[0]), 32'd0);
        reset = 1'b0;
        req = 32'd1 | (32'd1 << 5);
        tick();
        check("t5_first", 32'(a_o[0]), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_second", 32'(a_o[0]), 32'd5);

        // 6: unlimited hold keeps the owner while another waits
        do_reset();
        req = (32'd1 << 9) | (32'd1 << 10);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t6_hold", grant_o[2], 32'd1 << 9);
        end
        req = 32'd1 << 10;
        tick();
        check("t6_next", 32'(a_o[2]), 32'd10);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = $urandom;
                2:       req = $urandom & $urandom & $urandom;
                default: req = 32'd1 << $urandom_range(0, 31);
            endcase
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
